cic_agc_ctrl: RTL

- Automatic gain controller for the decimating CIC filter. It sequences the filter's output-shift `gain` input.
- It watches the filter's decimated output (x_out / out_tick) and measures the peak magnitude over fixed blocks of samples.
- It steps the gain up or down with hysteresis. It backs off fast on clipping, then waits for the filter pipeline to flush before measuring again.
- A manual mode passes a host-supplied gain through, clamped.

---
 rtl/cic_agc_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cic_agc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cic_agc_ctrl
//  Purpose  : Automatic gain controller for the decimating CIC filter. Sets
//             the filter's output-shift gain from the peak magnitude of
//             fixed-length blocks of decimated samples. The gain moves one
//             step at a time with hysteresis, backs off by two steps on a
//             full-scale sample, and waits for the pipeline to flush after
//             every change. A manual mode passes a host gain through, clamped.
//  Ports    : CLK          clock
//             RSTb         asynchronous active-low reset
//             agc_en       1 = automatic, 0 = manual
//             manual_gain  host gain used in manual mode
//             x_in/in_tick signed CIC output sample and its valid strobe
//             clip_clr     clears the sticky clip flag
//             gain         registered gain to the CIC
//             gain_update  1-cycle pulse in the cycle gain changes value
//             peak         peak magnitude of the last completed block
//             clip         sticky full-scale indicator
//             agc_state    IDLE=0 MEASURE=1 DECIDE=2 SETTLE=3
//  Revision : 1.0  initial release
// ============================================================================
module cic_agc_ctrl #(
    parameter int              BITS       = 16,
    parameter int              GAIN_BITS  = 8,
    parameter int              GAIN_MAX   = 40,
    parameter int              GAIN_INIT  = 0,
    parameter int              BLOCK_LEN  = 256,
    parameter int              SETTLE_LEN = 8,
    parameter logic [BITS-1:0] HI_THRESH  = 16'h6000,
    parameter logic [BITS-1:0] LO_THRESH  = 16'h1800
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic                 agc_en,
    input  logic [GAIN_BITS-1:0] manual_gain,
    input  logic [BITS-1:0]      x_in,
    input  logic                 in_tick,
    input  logic                 clip_clr,
    output logic [GAIN_BITS-1:0] gain,
    output logic                 gain_update,
    output logic [BITS-2:0]      peak,
    output logic                 clip,
    output logic [1:0]           agc_state
);

    // Counters are one bit wider than strictly needed so BLOCK_LEN itself fits.
    localparam int BCW = $clog2(BLOCK_LEN + 1);
    localparam int SCW = $clog2(SETTLE_LEN + 1);

    localparam logic [BCW-1:0]       BLK_LAST = BCW'(BLOCK_LEN - 1);
    localparam logic [SCW-1:0]       SET_LAST = SCW'(SETTLE_LEN - 1);
    localparam logic [GAIN_BITS-1:0] GMAX     = GAIN_BITS'(GAIN_MAX);
    localparam logic [GAIN_BITS-1:0] GINIT    = GAIN_BITS'(GAIN_INIT);
    localparam logic [GAIN_BITS-1:0] GONE     = GAIN_BITS'(1);
    localparam logic [GAIN_BITS-1:0] GTWO     = GAIN_BITS'(2);
    localparam logic [BITS-2:0]      HI       = HI_THRESH[BITS-2:0];
    localparam logic [BITS-2:0]      LO       = LO_THRESH[BITS-2:0];
    localparam logic [BITS-1:0]      X_MAX    = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0]      X_MIN    = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DECIDE  = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [GAIN_BITS-1:0] gain_nxt;
    logic [GAIN_BITS-1:0] manual_clamped;
    logic [BITS-2:0]      run_peak;
    logic [BITS-2:0]      run_peak_nxt;
    logic [BITS-2:0]      peak_nxt;
    logic [BCW-1:0]       blk_cnt;
    logic [BCW-1:0]       blk_cnt_nxt;
    logic [SCW-1:0]       set_cnt;
    logic [SCW-1:0]       set_cnt_nxt;
    logic                 clip_set;
    logic [BITS-1:0]      x_neg;
    logic [BITS-2:0]      mag;
    logic                 full_scale;

    // Magnitude on BITS-1 bits; the most negative code has no positive
    // counterpart and saturates to the largest magnitude.
    always_comb begin
        x_neg = {BITS{1'b0}} - x_in;
        if (x_in == X_MIN)
            mag = {(BITS-1){1'b1}};
        else if (x_in[BITS-1])
            mag = x_neg[BITS-2:0];
        else
            mag = x_in[BITS-2:0];
        full_scale = (x_in == X_MAX) || (x_in == X_MIN);
    end

    assign manual_clamped = (manual_gain > GMAX) ? GMAX : manual_gain;
    assign agc_state      = state;

    // Next-state and datapath decisions.
    always_comb begin
        state_nxt    = state;
        gain_nxt     = gain;
        run_peak_nxt = run_peak;
        blk_cnt_nxt  = blk_cnt;
        set_cnt_nxt  = set_cnt;
        peak_nxt     = peak;
        clip_set     = 1'b0;

        if (state == IDLE) begin
            run_peak_nxt = '0;
            blk_cnt_nxt  = '0;
            set_cnt_nxt  = '0;
            if (agc_en)
                state_nxt = MEASURE;   // automatic mode starts from the current gain
            else
                gain_nxt  = manual_clamped;
        end else if (!agc_en) begin
            // Leaving automatic mode discards any partial block; the manual
            // clamp is applied once IDLE has been reached.
            state_nxt    = IDLE;
            run_peak_nxt = '0;
            blk_cnt_nxt  = '0;
            set_cnt_nxt  = '0;
        end else begin
            case (state)
                MEASURE: begin
                    if (in_tick) begin
                        if (full_scale) begin
                            // Fast attack: drop two steps and abandon the block.
                            clip_set     = 1'b1;
                            gain_nxt     = (gain >= GTWO) ? (gain - GTWO) : '0;
                            state_nxt    = SETTLE;
                            run_peak_nxt = '0;
                            blk_cnt_nxt  = '0;
                            set_cnt_nxt  = '0;
                        end else begin
                            run_peak_nxt = (mag > run_peak) ? mag : run_peak;
                            blk_cnt_nxt  = blk_cnt + BCW'(1);
                            if (blk_cnt == BLK_LAST)
                                state_nxt = DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    peak_nxt = run_peak;
                    if ((run_peak >= HI) && (gain != '0))
                        gain_nxt = gain - GONE;
                    else if ((run_peak < LO) && (gain < GMAX))
                        gain_nxt = gain + GONE;
                    state_nxt    = (gain_nxt != gain) ? SETTLE : MEASURE;
                    run_peak_nxt = '0;
                    blk_cnt_nxt  = '0;
                    set_cnt_nxt  = '0;
                end
                SETTLE: begin
                    // Samples still carry the old gain through the filter
                    // pipeline; they are counted but not inspected.
                    if (in_tick) begin
                        if (set_cnt == SET_LAST) begin
                            state_nxt    = MEASURE;
                            set_cnt_nxt  = '0;
                            blk_cnt_nxt  = '0;
                            run_peak_nxt = '0;
                        end else begin
                            set_cnt_nxt = set_cnt + SCW'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            gain        <= GINIT;
            gain_update <= 1'b0;
            peak        <= '0;
            clip        <= 1'b0;
            run_peak    <= '0;
            blk_cnt     <= '0;
            set_cnt     <= '0;
        end else begin
            gain        <= gain_nxt;
            gain_update <= (gain_nxt != gain);
            peak        <= peak_nxt;
            clip        <= clip_set | (clip & ~clip_clr);   // set wins over clear
            run_peak    <= run_peak_nxt;
            blk_cnt     <= blk_cnt_nxt;
            set_cnt     <= set_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
